// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    // Controller states: waiting for a request, shifting bits, presenting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Operand width used when the instantiating block does not override it.
    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell; the only adder logic in the serial datapath.
module FA (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the three-input parity, carry is the three-input majority.
    always_comb begin
        sum  = x ^ y ^ cin;
        cout = (x & y) | (x & cin) | (y & cin);
    end

endmodule : FA

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one operand bit per cycle through a single full-adder cell,
// producing {cout,sum} = a + b + cin plus a two's-complement overflow flag.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_cout;

    // The one full-adder cell sees the operand LSBs and the running carry.
    FA u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and datapath update; everything holds unless a state says otherwise.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    // MSB cycle: carry_q is the carry into the MSB, fa_cout the carry out.
                    state_d = DONE;
                    cnt_d   = '0;
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Single state register for FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit, a request to begin one addition.
REQ-005 The module SHALL have port a, input, WIDTH bits, operand A, sampled only on an accepted start.
REQ-006 The module SHALL have port b, input, WIDTH bits, operand B, sampled only on an accepted start.
REQ-007 The module SHALL have port cin, input, 1 bit, carry-in, sampled only on an accepted start.
REQ-008 The module SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle pulse marking valid results.
REQ-010 The module SHALL have port sum, output, WIDTH bits, the result register.
REQ-011 The module SHALL have port cout, output, 1 bit, the unsigned carry-out of the MSB.
REQ-012 The module SHALL have port ovf, output, 1 bit, the two's-complement overflow flag (carry into MSB XOR carry out of MSB).

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after WIDTH RUN cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-014 On a start accepted in IDLE, the block SHALL load a and b into shift registers, load cin into the carry flop, and clear the bit counter to 0.
REQ-015 Each RUN cycle SHALL apply the LSB of each shift register and the carry flop to one full-adder cell, shift the sum bit into the MSB end of the sum shift register, shift both operand registers right, update the carry flop with the cell's carry-out, and increment the counter.
REQ-016 On the RUN cycle with counter = WIDTH-1, the block SHALL latch the cell's carry-in (into the MSB) for the ovf computation and transition to DONE.
REQ-017 Latency: if start is sampled at rising edge k, done SHALL be high exactly from edge k+WIDTH to edge k+WIDTH+1; sum, cout and ovf SHALL be valid from edge k+WIDTH.
REQ-018 sum, cout and ovf SHALL hold their values after DONE until the next accepted start.
REQ-019 start SHALL be ignored while in RUN or DONE; no operand resampling and no effect on sequencing.
REQ-020 With start held high continuously, a new operation SHALL be accepted on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-021 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-022 Arithmetic SHALL be {cout,sum} = a + b + cin, unsigned, mod 2^(WIDTH+1).

Reset
REQ-023 While rst_n=0, regardless of clk:
- state SHALL be IDLE;
- busy, done, cout, ovf and the carry flop SHALL be 0;
- sum SHALL be all zeros;
- the counter SHALL be 0.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation with no done pulse.
REQ-025 The first start sampled on or after the first rising edge following rst_n deassertion SHALL be accepted.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the constant DEFAULT_WIDTH = 8.
REQ-027 The bit datapath SHALL be exactly one instance of the team's existing full-adder cell FA (x, y, cin, sum, cout); no other adder logic is permitted.

Verification (WIDTH=8)
REQ-028 Basic add: a=0x3C, b=0x5A, cin=0 -> sum=0x96, cout=0, ovf=1, with done 8 edges after start.
REQ-029 Carry-in and unsigned carry: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0. Also a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-030 Signed overflow with carry: a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
REQ-031 start pulsed mid-RUN with different operands -> ignored; the result is from the first operands; exactly one done pulse.
REQ-032 rst_n pulled low at RUN cycle 4 -> outputs go to 0 immediately; no done pulse. A new start after release with 0x01+0x02 -> sum=0x03.
REQ-033 start held high for 3 operations -> done pulses spaced exactly 10 cycles apart; each result is correct; busy drops for exactly one cycle between operations.
